// File: rtl/dec_out_fifo_if.sv
// rtl/dec_out_fifo_if.sv - sample-in / FIFO-out bundle for dec_out_fifo
interface dec_out_fifo_if #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16,
  parameter int DEPTH = 8
);
  logic signed [IN_W-1:0]  in;
  logic                    valid_in;
  logic [4:0]              shift;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic                    clr_ovf;

  modport master (
    output in, valid_in, shift, out_ready, clr_ovf,
    input  out_data, out_valid, level, overflow
  );

  modport slave (
    input  in, valid_in, shift, out_ready, clr_ovf,
    output out_data, out_valid, level, overflow
  );
endinterface

// File: rtl/dec_out_fifo.sv
// rtl/dec_out_fifo.sv - round/shift/saturate formatter feeding a FWFT FIFO with sticky overflow
module dec_out_fifo #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16,
  parameter int DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  dec_out_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic signed [IN_W:0] ONE  = {{IN_W{1'b0}}, 1'b1};
  localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0]    w_rnd;
  logic signed [IN_W:0]    w_t;
  logic signed [IN_W:0]    w_sh;
  logic signed [OUT_W-1:0] w_sat;

  logic signed [OUT_W-1:0] r_fmt_data;
  logic                    r_fmt_valid;
  logic signed [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [LW-1:0]           r_level;
  logic                    r_overflow;

  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    w_rnd = (bus.shift == 5'd0) ? '0 : (ONE << (bus.shift - 5'd1));
    w_t   = {bus.in[IN_W-1], bus.in} + w_rnd;
    w_sh  = w_t >>> bus.shift;
    if (w_sh > MAXV) begin
      w_sat = MAXV[OUT_W-1:0];
    end else if (w_sh < MINV) begin
      w_sat = MINV[OUT_W-1:0];
    end else begin
      w_sat = w_sh[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fmt_valid <= 1'b0;
      r_fmt_data  <= '0;
    end else begin
      r_fmt_valid <= bus.valid_in;
      if (bus.valid_in) begin
        r_fmt_data <= w_sat;
      end
    end
  end

  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_pop  = (r_level != '0) && bus.out_ready;
  assign w_full = (r_level == LW'(DEPTH));
  assign w_push = r_fmt_valid && (!w_full || w_pop);
  assign w_drop = r_fmt_valid && !w_push;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= r_fmt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.out_valid = (r_level != '0);
  assign bus.out_data  = bus.out_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;
endmodule

// File: doc/dec_out_fifo.md
# dec_out_fifo

Output formatting and buffering stage that sits directly downstream of the 128x decimation chain. It consumes the chain's 33-bit signed samples and their one-cycle valid strobe, then scales each sample by a programmable arithmetic right shift with rounding and saturates it to the output width. Formatted samples are buffered in a small first-word-fall-through FIFO behind a valid/ready interface, and a sticky overflow flag records any sample dropped because the FIFO was full.

## Interface
- IN_W, 33, input sample width (signed)
- OUT_W, 16, output sample width (signed), OUT_W < IN_W
- DEPTH, 8, FIFO depth in words, power of two, ≥ 2
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in  input  IN_W  signed sample from the decimation chain
- valid_in  input  1  one-cycle strobe, `in` valid this cycle
- shift  input  5  right-shift amount 0..31, sampled when valid_in=1
- out_data  output  OUT_W  FIFO head sample, valid while out_valid=1
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts head this cycle
- level  output  $clog2(DEPTH)+1  current FIFO occupancy 0..DEPTH
- overflow  output  1  sticky, a formatted sample was dropped
- clr_ovf  input  1  clears overflow

## Operation
- Format stage, registered:
  - On valid_in, compute `t = in + (shift>0 ? 2^(shift-1) : 0)` in IN_W+1 bits, so the addition cannot wrap.
  - Then `t >>> shift`, an arithmetic shift that rounds half toward +inf.
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Result is registered into fmt_data, with fmt_valid=1 for exactly one cycle.
  - When valid_in=0, fmt_valid=0 and fmt_data holds.
- FIFO, DEPTH entries, with write/read pointers of $clog2(DEPTH) bits plus a level counter:
  - push = fmt_valid and (level<DEPTH or pop).
  - pop = out_valid and out_ready.
  - Pointers wrap modulo DEPTH.
  - Level changes as follows: +1 on push only, −1 on pop only, unchanged on both.
- Full with simultaneous pop: push is accepted and level stays DEPTH.
- Full without pop: the fmt sample is dropped, memory is unchanged, and overflow is set on the next edge.
- Empty with simultaneous push: no pop is possible because out_valid=0. The word appears at out_data the next cycle.
- Output is first-word-fall-through: out_data = mem[rd_ptr] whenever level>0. When level=0, out_data is don't-care, and the bench must not check it.
- Overflow:
  - Set on a drop.
  - Cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins.
- Reset mid-operation: all content is discarded, and any in-flight fmt sample is lost.
- Back-pressure cannot reach the chain, because the chain has no stall. Loss is flagged, never blocking.

## Timing
- Reset values:
  - out_valid=0, level=0, overflow=0.
  - out_data=0, fmt_valid=0.
  - rd_ptr=wr_ptr=0.
- Latency:
  - valid_in at edge N gives fmt_valid at N+1.
  - The word is written at the N+1 edge, so out_valid=1 from N+2 when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- The nominal input rate from the chain is one sample per 128 clocks.
- out_data and out_valid are stable until a pop; the consumer may hold out_ready low indefinitely.
- level updates on the same edge as the push or pop.
- overflow asserts on the edge following the dropped fmt_valid cycle.

## Test plan
- Reset, then in=33'sd1000, shift=0, valid_in pulse at cycle 5 -> out_valid=1 at cycle 7 with out_data=1000; level=1; out_ready=1 at cycle 8 -> level=0, out_valid=0 at cycle 9.
- Rounding, shift=4:
  - in=24 -> 2 (24+8=32, 32>>>4=2).
  - in=23 -> 1.
  - in=−24 -> −1.
  - in=−25 -> −2.
  - shift=1, in=−1 -> 0.
- Saturation, shift=0, OUT_W=16:
  - in=40000 -> 32767.
  - in=−40000 -> −32768.
  - in=2^32−1 with shift=31 -> 2.
- Fill with out_ready=0: 8 samples 1..8 -> level=8, overflow=0; 9th sample -> dropped, overflow=1, level=8; drain reads 1..8 in order.
- Full with push and pop in the same cycle: samples 1..8, then a 9th sample whose fmt_valid cycle coincides with out_ready=1 -> pop returns 1, sample 9 is accepted, level stays 8, overflow=0; the drain sequence is 2..9.
- Flags and reset:
  - clr_ovf coinciding with a drop -> overflow stays 1.
  - clr_ovf alone -> overflow=0.
  - rst asserted at level=5 -> next cycle level=0, out_valid=0, overflow=0.
  - A subsequent sample appears 2 cycles after its valid_in.
